el2_ifu_bp_upd_ctl: RTL and testbench

Training side of the IFU branch predictor. It accepts branch-resolution updates from the EXU and buffers them in a small FIFO. It computes new 2-bit BHT counters and BTB allocate/invalidate decisions, then drives registered write ports into the BHT/BTB arrays. Writes are held off while fetch owns the arrays.

---
 rtl/el2_ifu_bp_pkg.sv | 39 +++
 rtl/el2_ifu_bp_upd_fifo.sv | 44 ++++
 rtl/el2_ifu_bp_upd_ctl.sv | 125 ++++++++++++
 tb/tb_el2_ifu_bp_upd_ctl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/el2_ifu_bp_pkg.sv
// Shared types and helpers for the IFU branch-predictor training path.
// Holds default widths, the update and BTB entry bundles, and 2-bit counter arithmetic.
package el2_ifu_bp_pkg;

   localparam int IDX_W_DEF = 8;
   localparam int TAG_W_DEF = 5;
   localparam int TGT_W_DEF = 31;

   typedef logic [1:0] ctr_t;

   localparam ctr_t SNT = 2'd0;
   localparam ctr_t WNT = 2'd1;
   localparam ctr_t WT  = 2'd2;
   localparam ctr_t ST  = 2'd3;

   typedef struct packed {
      logic [IDX_W_DEF-1:0] index;
      logic [TAG_W_DEF-1:0] tag;
      logic                 taken;
      logic                 mispredict;
      ctr_t                 hist;
      logic [TGT_W_DEF-1:0] tgt;
   } upd_rec_t;

   typedef struct packed {
      logic                 valid;
      logic [TAG_W_DEF-1:0] tag;
      logic [TGT_W_DEF-1:0] tgt;
   } btb_entry_t;

   // Saturating step of the 2-bit direction counter toward the resolved direction.
   function automatic ctr_t ctr_next(input logic taken, input ctr_t hist);
      ctr_t res;
      if (taken) res = (hist == ST)  ? ST  : ctr_t'(hist + 2'd1);
      else       res = (hist == SNT) ? SNT : ctr_t'(hist - 2'd1);
      return res;
   endfunction

endpackage

// File: rtl/el2_ifu_bp_upd_fifo.sv
// Generic DEPTH-entry synchronous FIFO for branch-update records.
// Pointers carry an extra wrap bit so full and empty are distinguishable.
module el2_ifu_bp_upd_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             enq_i,
   input  logic [WIDTH-1:0] enq_data_i,
   input  logic             deq_i,
   output logic [WIDTH-1:0] deq_data_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wptr_q, rptr_q;
   logic             do_enq, do_deq;

   assign empty_o    = (wptr_q == rptr_q);
   assign full_o     = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign do_enq     = enq_i && !full_o;
   assign do_deq     = deq_i && !empty_o;
   assign deq_data_o = mem_q[rptr_q[AW-1:0]];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         if (do_enq) wptr_q <= wptr_q + 1'b1;
         if (do_deq) rptr_q <= rptr_q + 1'b1;
      end
   end

   // Storage needs no reset: the pointers alone decide what is valid.
   always_ff @(posedge clk_i) begin
      if (do_enq) mem_q[wptr_q[AW-1:0]] <= enq_data_i;
   end

endmodule

// File: rtl/el2_ifu_bp_upd_ctl.sv
// Branch-predictor training control: queues EXU resolutions, derives BHT/BTB
// updates from the queue head and drives single-cycle registered array writes.
module el2_ifu_bp_upd_ctl
   import el2_ifu_bp_pkg::*;
#(
   parameter int IDX_W = IDX_W_DEF,
   parameter int TAG_W = TAG_W_DEF,
   parameter int TGT_W = TGT_W_DEF,
   parameter int DEPTH = 2
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   io_upd_valid,
   output logic                   io_upd_ready,
   input  logic [IDX_W-1:0]       io_upd_index,
   input  logic [TAG_W-1:0]       io_upd_tag,
   input  logic                   io_upd_taken,
   input  logic                   io_upd_mispredict,
   input  logic [1:0]             io_upd_hist,
   input  logic [TGT_W-1:0]       io_upd_tgt,
   input  logic                   io_wr_stall,
   output logic                   io_bht_wen,
   output logic [IDX_W-1:0]       io_bht_waddr,
   output logic [1:0]             io_bht_wdata,
   output logic                   io_btb_wen,
   output logic [IDX_W-1:0]       io_btb_waddr,
   output logic [TAG_W+TGT_W:0]   io_btb_wdata,
   output logic [7:0]             io_filtered_cnt,
   output logic                   io_busy
);

   typedef struct packed {
      logic [IDX_W-1:0] index;
      logic [TAG_W-1:0] tag;
      logic             taken;
      logic             mispredict;
      ctr_t             hist;
      logic [TGT_W-1:0] tgt;
   } rec_t;

   rec_t               enq_rec, head;
   logic               full, empty, pop;
   ctr_t               nh;
   logic               bht_need, btb_alloc, btb_inv, btb_need;
   logic [TAG_W+TGT_W:0] btb_entry;

   logic                 bht_wen_q, btb_wen_q;
   logic [IDX_W-1:0]     bht_waddr_q, btb_waddr_q;
   ctr_t                 bht_wdata_q;
   logic [TAG_W+TGT_W:0] btb_wdata_q;
   logic [7:0]           flt_cnt_q, flt_cnt_d;

   assign enq_rec = '{index: io_upd_index, tag: io_upd_tag, taken: io_upd_taken,
                      mispredict: io_upd_mispredict, hist: io_upd_hist, tgt: io_upd_tgt};

   el2_ifu_bp_upd_fifo #(
      .WIDTH ($bits(rec_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i      (clock),
      .rst_i      (reset),
      .enq_i      (io_upd_valid),
      .enq_data_i (enq_rec),
      .deq_i      (pop),
      .deq_data_o (head),
      .full_o     (full),
      .empty_o    (empty)
   );

   assign io_upd_ready = !full;
   // Fetch owning the arrays freezes the head; filtered heads also wait their turn.
   assign pop = !empty && !io_wr_stall;

   always_comb begin
      nh        = ctr_next(head.taken, head.hist);
      bht_need  = (nh != head.hist) || head.mispredict;
      btb_alloc = head.taken && (head.mispredict || (head.hist < WT));
      btb_inv   = !head.taken && (nh == SNT) && (head.hist != SNT);
      btb_need  = btb_alloc || btb_inv;
      btb_entry = '0;
      if (btb_alloc)    btb_entry = {1'b1, head.tag, head.tgt};
      else if (btb_inv) btb_entry = {1'b0, head.tag, {TGT_W{1'b0}}};
   end

   always_comb begin
      flt_cnt_d = flt_cnt_q;
      if (pop && !bht_need && !btb_need && (flt_cnt_q != 8'hFF))
         flt_cnt_d = flt_cnt_q + 8'd1;
   end

   // Write stage: strobes last exactly one cycle, address/data hold until the next write.
   always_ff @(posedge clock) begin
      if (reset) begin
         bht_wen_q   <= 1'b0;
         btb_wen_q   <= 1'b0;
         bht_waddr_q <= '0;
         btb_waddr_q <= '0;
         bht_wdata_q <= SNT;
         btb_wdata_q <= '0;
         flt_cnt_q   <= '0;
      end else begin
         bht_wen_q <= pop && bht_need;
         btb_wen_q <= pop && btb_need;
         flt_cnt_q <= flt_cnt_d;
         if (pop && bht_need) begin
            bht_waddr_q <= head.index;
            bht_wdata_q <= nh;
         end
         if (pop && btb_need) begin
            btb_waddr_q <= head.index;
            btb_wdata_q <= btb_entry;
         end
      end
   end

   assign io_bht_wen      = bht_wen_q;
   assign io_bht_waddr    = bht_waddr_q;
   assign io_bht_wdata    = bht_wdata_q;
   assign io_btb_wen      = btb_wen_q;
   assign io_btb_waddr    = btb_waddr_q;
   assign io_btb_wdata    = btb_wdata_q;
   assign io_filtered_cnt = flt_cnt_q;
   assign io_busy         = !empty || bht_wen_q || btb_wen_q;

endmodule

// File: tb/tb_el2_ifu_bp_upd_ctl.sv
// Directed bench for el2_ifu_bp_upd_ctl: drives on the falling edge, samples
// on the falling edge, expected values written out by hand.
module tb_el2_ifu_bp_upd_ctl;

   logic        clock = 1'b0;
   logic        reset;
   logic        io_upd_valid;
   logic        io_upd_ready;
   logic [7:0]  io_upd_index;
   logic [4:0]  io_upd_tag;
   logic        io_upd_taken;
   logic        io_upd_mispredict;
   logic [1:0]  io_upd_hist;
   logic [30:0] io_upd_tgt;
   logic        io_wr_stall;
   logic        io_bht_wen;
   logic [7:0]  io_bht_waddr;
   logic [1:0]  io_bht_wdata;
   logic        io_btb_wen;
   logic [7:0]  io_btb_waddr;
   logic [36:0] io_btb_wdata;
   logic [7:0]  io_filtered_cnt;
   logic        io_busy;

   int checks   = 0;
   int failures = 0;

   always #5 clock = ~clock;

   el2_ifu_bp_upd_ctl dut (
      .clock             (clock),
      .reset             (reset),
      .io_upd_valid      (io_upd_valid),
      .io_upd_ready      (io_upd_ready),
      .io_upd_index      (io_upd_index),
      .io_upd_tag        (io_upd_tag),
      .io_upd_taken      (io_upd_taken),
      .io_upd_mispredict (io_upd_mispredict),
      .io_upd_hist       (io_upd_hist),
      .io_upd_tgt        (io_upd_tgt),
      .io_wr_stall       (io_wr_stall),
      .io_bht_wen        (io_bht_wen),
      .io_bht_waddr      (io_bht_waddr),
      .io_bht_wdata      (io_bht_wdata),
      .io_btb_wen        (io_btb_wen),
      .io_btb_waddr      (io_btb_waddr),
      .io_btb_wdata      (io_btb_wdata),
      .io_filtered_cnt   (io_filtered_cnt),
      .io_busy           (io_busy)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic [7:0] idx, input logic [4:0] tg, input logic tk,
                        input logic mp, input logic [1:0] h, input logic [30:0] tgt);
      io_upd_valid      = 1'b1;
      io_upd_index      = idx;
      io_upd_tag        = tg;
      io_upd_taken      = tk;
      io_upd_mispredict = mp;
      io_upd_hist       = h;
      io_upd_tgt        = tgt;
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clock);
   endtask

   initial begin
      reset = 1'b1;
      io_upd_valid = 1'b0;
      io_upd_index = '0;
      io_upd_tag = '0;
      io_upd_taken = 1'b0;
      io_upd_mispredict = 1'b0;
      io_upd_hist = '0;
      io_upd_tgt = '0;
      io_wr_stall = 1'b0;
      cyc(2);
      chk("rst_bht_wen", io_bht_wen, 0);
      chk("rst_btb_wen", io_btb_wen, 0);
      chk("rst_btb_wdata", io_btb_wdata, 0);
      chk("rst_cnt", io_filtered_cnt, 0);
      reset = 1'b0;
      cyc(1);
      chk("rst_ready", io_upd_ready, 1);
      chk("rst_busy", io_busy, 0);

      // Allocate on mispredicted taken branch
      drive(8'h12, 5'h0A, 1, 1, 2'd1, 31'h4000);
      cyc(1);
      io_upd_valid = 1'b0;
      chk("t1_n1_bht_wen", io_bht_wen, 0);
      chk("t1_n1_busy", io_busy, 1);
      cyc(1);
      chk("t1_bht_wen", io_bht_wen, 1);
      chk("t1_bht_waddr", io_bht_waddr, 8'h12);
      chk("t1_bht_wdata", io_bht_wdata, 2);
      chk("t1_btb_wen", io_btb_wen, 1);
      chk("t1_btb_waddr", io_btb_waddr, 8'h12);
      chk("t1_btb_wdata", io_btb_wdata, {1'b1, 5'h0A, 31'h4000});
      cyc(1);
      chk("t1_bht_wen_off", io_bht_wen, 0);
      chk("t1_btb_wen_off", io_btb_wen, 0);
      chk("t1_busy_off", io_busy, 0);

      // Strongly taken stays strongly taken: filtered
      drive(8'h20, 5'h01, 1, 0, 2'd3, 31'h55);
      cyc(1);
      io_upd_valid = 1'b0;
      chk("t2_busy", io_busy, 1);
      chk("t2_cnt0", io_filtered_cnt, 0);
      cyc(1);
      chk("t2_bht_wen", io_bht_wen, 0);
      chk("t2_btb_wen", io_btb_wen, 0);
      chk("t2_cnt1", io_filtered_cnt, 1);
      chk("t2_busy_fall", io_busy, 0);

      // Weakly not-taken resolved not-taken: invalidate
      drive(8'h34, 5'h03, 0, 0, 2'd1, 31'h123);
      cyc(2);
      io_upd_valid = 1'b0;
      chk("t3_bht_wen", io_bht_wen, 1);
      chk("t3_bht_wdata", io_bht_wdata, 0);
      chk("t3_btb_wen", io_btb_wen, 1);
      chk("t3_btb_waddr", io_btb_waddr, 8'h34);
      chk("t3_btb_wdata", io_btb_wdata, {1'b0, 5'h03, 31'h0});
      cyc(1);

      // Strongly not-taken resolved not-taken: filtered
      drive(8'h35, 5'h03, 0, 0, 2'd0, 31'h0);
      cyc(1);
      io_upd_valid = 1'b0;
      cyc(1);
      chk("t4_bht_wen", io_bht_wen, 0);
      chk("t4_btb_wen", io_btb_wen, 0);
      chk("t4_cnt", io_filtered_cnt, 2);

      // Stall with three back-to-back updates
      io_wr_stall = 1'b1;
      drive(8'h01, 5'h11, 1, 0, 2'd0, 31'h100);
      cyc(1);
      chk("t5_ready_a", io_upd_ready, 1);
      drive(8'h02, 5'h12, 1, 0, 2'd2, 31'h200);
      cyc(1);
      chk("t5_ready_full", io_upd_ready, 0);
      drive(8'h03, 5'h13, 0, 1, 2'd3, 31'h300);
      cyc(1);
      chk("t5_ready_still", io_upd_ready, 0);
      chk("t5_stall_bht", io_bht_wen, 0);
      chk("t5_stall_btb", io_btb_wen, 0);
      io_wr_stall = 1'b0;
      cyc(1);
      chk("t5_a_bht_wen", io_bht_wen, 1);
      chk("t5_a_bht_waddr", io_bht_waddr, 8'h01);
      chk("t5_a_bht_wdata", io_bht_wdata, 1);
      chk("t5_a_btb_wen", io_btb_wen, 1);
      chk("t5_a_btb_wdata", io_btb_wdata, {1'b1, 5'h11, 31'h100});
      chk("t5_ready_after_pop", io_upd_ready, 1);
      cyc(1);
      io_upd_valid = 1'b0;
      chk("t5_b_bht_wen", io_bht_wen, 1);
      chk("t5_b_bht_waddr", io_bht_waddr, 8'h02);
      chk("t5_b_bht_wdata", io_bht_wdata, 3);
      chk("t5_b_btb_wen", io_btb_wen, 0);
      cyc(1);
      chk("t5_c_bht_wen", io_bht_wen, 1);
      chk("t5_c_bht_waddr", io_bht_waddr, 8'h03);
      chk("t5_c_bht_wdata", io_bht_wdata, 2);
      chk("t5_c_btb_wen", io_btb_wen, 0);
      cyc(1);
      chk("t5_done_wen", io_bht_wen, 0);
      chk("t5_done_busy", io_busy, 0);

      // Reset with two queued entries
      io_wr_stall = 1'b1;
      drive(8'h40, 5'h04, 1, 1, 2'd1, 31'h40);
      cyc(1);
      drive(8'h41, 5'h05, 1, 1, 2'd1, 31'h41);
      cyc(1);
      io_upd_valid = 1'b0;
      chk("t6_busy_pre", io_busy, 1);
      reset = 1'b1;
      cyc(1);
      reset = 1'b0;
      io_wr_stall = 1'b0;
      chk("t6_busy", io_busy, 0);
      chk("t6_cnt", io_filtered_cnt, 0);
      for (int i = 0; i < 3; i++) begin
         cyc(1);
         chk("t6_bht_wen", io_bht_wen, 0);
         chk("t6_btb_wen", io_btb_wen, 0);
      end
      chk("t6_ready", io_upd_ready, 1);

      // Filtered-count saturation
      drive(8'h50, 5'h00, 0, 0, 2'd0, 31'h0);
      cyc(100);
      io_upd_valid = 1'b0;
      cyc(3);
      chk("t7_cnt100", io_filtered_cnt, 100);
      io_upd_valid = 1'b1;
      cyc(200);
      io_upd_valid = 1'b0;
      cyc(3);
      chk("t7_cnt_sat", io_filtered_cnt, 255);
      chk("t7_busy", io_busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
